// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous-read RAM: one command at a time, contiguous ascending addresses.
// Latency: write beat lands at its accept edge; read beat reaches rd_valid two cycles after its address issue.
// Backpressure: wr_valid low stalls writes; read issue is credit-limited against a 2-entry output buffer.
// Optional feature macro: RAM_BURST_CTRL_WRAP_CHK_EN (reject bursts that would wrap the address space).
module ram_burst_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH-1:0] cmd_len,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [AWIDTH-1:0] r_cur_addr;
  logic [AWIDTH-1:0] r_remaining;
  logic              r_inflight;
  logic              r_done;

  // Output buffer: two entries, separate read/write pointers plus occupancy.
  logic [DWIDTH-1:0] r_buf [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_count_nxt;
  logic [2:0]        w_credit;
  logic              w_cmd_acc;
  logic              w_wr_acc;
  logic              w_issue;
  logic              w_finish;
  logic              w_drop;
  logic              w_wrap;

  assign w_pop       = rd_valid && rd_ready;
  assign w_push      = r_inflight;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  // Slots that will be claimed after this edge: entries kept plus the beat still in the RAM pipeline.
  assign w_credit    = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};

  assign w_wrap = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > {1'b0, {AWIDTH{1'b1}}};

`ifdef RAM_BURST_CTRL_WRAP_CHK_EN
  assign w_drop = w_wrap;
`else
  assign w_drop = 1'b0;
`endif

  assign rd_valid = (r_count != 2'd0);
  assign rd_data  = r_buf[r_rd_ptr];
  assign ram_addr = r_cur_addr;
  assign ram_din  = wr_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state handshake/RAM strobes.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    w_cmd_acc   = 1'b0;
    w_wr_acc    = 1'b0;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !w_drop) begin
          w_cmd_acc   = 1'b1;
          w_state_nxt = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        w_wr_acc = wr_valid;
        if (wr_valid && (r_remaining == '0)) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      S_READ: begin
        w_issue = (w_credit < 3'd2);
        if (w_issue && (r_remaining == '0)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finished once nothing remains in the RAM pipeline and the last entry leaves.
        if (!r_inflight && (w_count_nxt == 2'd0)) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst address/beat bookkeeping, read pipeline flag and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_cmd_acc) begin
        r_cur_addr  <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_wr_acc || w_issue) begin
        r_cur_addr  <= r_cur_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      r_inflight <= w_issue;
      r_done     <= w_finish;
    end
  end

  // Output buffer: capture RAM data one cycle after issue, release on rd handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= ram_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef RAM_BURST_CTRL_WRAP_CHK_EN
  logic r_err;

  // Rejection pulse for a command that would wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && cmd_valid && w_drop;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
